alu_control_unit: RTL and testbench
===================================

# alu_control_unit

Multi-cycle sequencer that time-shares a single `adder_rca` instance, `W+1` bits wide, for signed ADD, SUB and radix-2 Booth MUL. It sits between the ALU operand/opcode registers and the result bus. It accepts one operation per start/done handshake and drives the adder's `x`, `y` and `carry_in` every cycle. It is the only owner of the adder; no other block drives it.

## Interface
- `W`, default 8: operand width; internal adder width W+1, result width 2W.

- `clk` in 1: clock, rising edge.
- `rst_b` in 1: asynchronous active-low reset.
- `start` in 1: request; sampled only in IDLE.
- `op` in 2: 00 ADD, 01 SUB, 10 MUL (signed Booth), 11 reserved.
- `x` in W: signed operand A / multiplicand.
- `y` in W: signed operand B / multiplier.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `result`, `ovf`, `err` valid while high and held until next accepted start.
- `result` out 2W: signed result.
- `ovf` out 1: ADD/SUB W-bit signed overflow; 0 for MUL.
- `err` out 1: reserved opcode seen.

## Operation
- States: IDLE, EXEC, MADD, MSHIFT, DONE.
- IDLE, `start`=1:
  - latch `x`, `y`, `op`.
  - op 00/01 go to EXEC.
  - op 10: A=0 (W+1 bits), Q=y, Q₋₁=0, M=sext(x), count=0, go to MADD.
  - op 11 goes to DONE with `result`=0, `err`=1.
- EXEC:
  - adder computes sext(x) + sext(y) (ADD), or sext(x) + ~sext(y) with carry_in=1 (SUB).
  - register the 9-bit sum sign-extended to 2W.
  - `ovf` = sum[W] ^ sum[W-1].
  - go to DONE.
- MADD: look at {Q[0],Q₋₁}.
  - 01: A = A+M.
  - 10: A = A+~M with carry_in=1.
  - 00/11: A unchanged (adder output discarded).
  - go to MSHIFT.
- MSHIFT:
  - arithmetic shift right of {A,Q,Q₋₁} by 1; count++.
  - count reaches W: `result` = {A[W-1:0],Q}, go to DONE.
  - otherwise go to MADD.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Adder carry_out is ignored; all arithmetic is modulo 2^(W+1) in A.
- `start` outside IDLE is ignored; no queueing. `x`/`y`/`op` changes after acceptance have no effect.
- `err` and `ovf` clear on the next accepted start.

## Timing
- Reset value of every output is 0: `busy`, `done`, `result`, `ovf`, `err`. State is IDLE, internal registers are 0.
- `rst_b` low mid-operation aborts immediately, with no `done`; recovery is in IDLE on the first edge after release.
- Start accepted at edge N, with `busy` high from N.
- `done` latency:
  - ADD/SUB: `done` high after edge N+2 (EXEC at N+1).
  - MUL: `done` high after edge N+2W+1, i.e. 17 for W=8.
  - reserved op: `done` high after edge N+1.
- Back-to-back: the earliest next acceptance is the edge after DONE, so `busy` is low for at least one cycle.

## Configuration
- `ALU_CTRL_SKIP_EN` defined: MADD is skipped when {Q[0],Q₋₁} is 00 or 11.
  - IDLE and MSHIFT go straight to MSHIFT in that case.
  - MUL latency = 1 + W + (number of add/sub iterations) edges; W=8, `y`=0 gives `done` after N+9.
- Macro undefined: fixed MUL latency as stated in Timing; results are identical in both builds.

## Test plan
- ADD 3+2 and SUB 5−3: `result`=16'd5 / 16'd2, `ovf`=0, `done` exactly after edge N+2.
- ADD 127+1: `result`=16'd128, `ovf`=1. SUB 0−1: `result`=16'hFFFF, `ovf`=0. SUB −128−1: `ovf`=1.
- MUL 3×−2: 16'hFFFA. MUL −128×−128: 16'd16384. MUL 0×85: 0. `done` after edge N+17 without the macro; 100 random signed pairs match a reference model.
- `start` pulsed with new operands while `busy`: ignored, first result unchanged. `op`=11: `err`=1, `result`=0, `done` after N+1.
- `rst_b` low at MADD of iteration 4: all outputs 0 asynchronously, no `done`. A fresh MUL 5×5 afterwards gives 16'd25.
- With `ALU_CTRL_SKIP_EN`: MUL 7×0 gives `done` after N+9. MUL 7×−1 (one sub iteration) gives `done` after N+10, `result`=16'hFFF9.

Source files
------------

// File: rtl/alu_control_unit_if.sv
// Operand/opcode request and result bus between the ALU registers and the ALU sequencer.
interface alu_control_unit_if #(
  parameter int W = 8
);
  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           ovf;
  logic           err;

  modport master (output start, op, x, y, input busy, done, result, ovf, err);
  modport slave  (input start, op, x, y, output busy, done, result, ovf, err);
endinterface

// File: rtl/alu_control_unit.sv
// Multi-cycle ADD/SUB/Booth-MUL sequencer sharing one W+1 bit ripple adder; done 2 / 2W+1 / 1 edges after start.
// No queueing: start is ignored while busy. ALU_CTRL_SKIP_EN skips Booth no-op add cycles.
module adder_rca #(
  parameter int N = 9
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);
  logic [N:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign carry_out = c[N];
endmodule

module alu_control_unit #(
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  alu_control_unit_if.slave bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {IDLE, EXEC, MADD, MSHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   xa, yb;
  logic [1:0]     opc;
  logic [W:0]     acc;
  logic [W-1:0]   q;
  logic           q_m1;
  logic [CW-1:0]  count;
  logic [2*W-1:0] result_r;
  logic           done_r, ovf_r, err_r;

  logic [W:0]     mcand;
  logic [W:0]     add_x, add_y, add_sum;
  logic           add_cin, carry_unused;
  logic [1:0]     booth_bits;
  logic [2*W+1:0] shifted;

  assign mcand      = {xa[W-1], xa};
  assign booth_bits = {q[0], q_m1};
  assign shifted    = $unsigned($signed({acc, q, q_m1}) >>> 1);

  adder_rca #(.N(W + 1)) u_adder (
    .x         (add_x),
    .y         (add_y),
    .carry_in  (add_cin),
    .sum       (add_sum),
    .carry_out (carry_unused)
  );

  always_comb begin
    state_nxt = state;
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            2'b00, 2'b01: state_nxt = EXEC;
`ifdef ALU_CTRL_SKIP_EN
            // Q-1 starts at 0, so only y[0]=1 needs an adder pass first
            2'b10:        state_nxt = bus.y[0] ? MADD : MSHIFT;
`else
            2'b10:        state_nxt = MADD;
`endif
            default:      state_nxt = DONE;
          endcase
        end
      end
      EXEC: begin
        add_x     = {xa[W-1], xa};
        add_y     = opc[0] ? ~{yb[W-1], yb} : {yb[W-1], yb};
        add_cin   = opc[0];
        state_nxt = DONE;
      end
      MADD: begin
        add_x     = acc;
        add_y     = (booth_bits == 2'b10) ? ~mcand : mcand;
        add_cin   = (booth_bits == 2'b10);
        state_nxt = MSHIFT;
      end
      MSHIFT: begin
        if (count == CW'(W - 1)) begin
          state_nxt = DONE;
        end else begin
`ifdef ALU_CTRL_SKIP_EN
          // shifted[1:0] are the next {Q[0], Q-1} pair
          state_nxt = (shifted[1] ^ shifted[0]) ? MADD : MSHIFT;
`else
          state_nxt = MADD;
`endif
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      xa       <= '0;
      yb       <= '0;
      opc      <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      count    <= '0;
      result_r <= '0;
      done_r   <= 1'b0;
      ovf_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_r <= (state == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            xa       <= bus.x;
            yb       <= bus.y;
            opc      <= bus.op;
            acc      <= '0;
            q        <= bus.y;
            q_m1     <= 1'b0;
            count    <= '0;
            result_r <= '0;
            ovf_r    <= 1'b0;
            err_r    <= (bus.op == 2'b11);
          end
        end
        EXEC: begin
          result_r <= {{(W - 1){add_sum[W]}}, add_sum};
          ovf_r    <= add_sum[W] ^ add_sum[W-1];
        end
        MADD: begin
          if (booth_bits[1] ^ booth_bits[0]) acc <= add_sum;
        end
        MSHIFT: begin
          {acc, q, q_m1} <= shifted;
          count          <= count + 1'b1;
          if (count == CW'(W - 1)) result_r <= shifted[2*W:1];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.ovf    = ovf_r;
  assign bus.err    = err_r;
endmodule

// File: tb/tb_alu_control_unit.sv
// Directed and random checks of the ALU sequencer: latencies, results, flags, abort and start-while-busy.
module tb_alu_control_unit;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  alu_control_unit_if #(.W(8)) bus();

  alu_control_unit #(.W(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  // ADD/SUB vectors: op, x, y, expected result, expected ovf
  logic [1:0]  as_op  [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
  logic [7:0]  as_x   [6] = '{8'd3, 8'd5, 8'd127, 8'd0, 8'h80, 8'h80};
  logic [7:0]  as_y   [6] = '{8'd2, 8'd3, 8'd1, 8'd1, 8'd1, 8'h80};
  logic [15:0] as_res [6] = '{16'd5, 16'd2, 16'd128, 16'hFFFF, 16'hFF7F, 16'hFF00};
  logic        as_ovf [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

  logic [7:0]  m_x   [7] = '{8'd3, 8'h80, 8'd0, 8'd7, 8'd5, 8'd127, 8'h80};
  logic [7:0]  m_y   [7] = '{8'hFE, 8'h80, 8'd85, 8'hFF, 8'd5, 8'd127, 8'd127};
  logic [15:0] m_res [7] = '{16'hFFFA, 16'd16384, 16'd0, 16'hFFF9, 16'd25, 16'h3F01, 16'hC080};

  task automatic run_op(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [15:0] res, output logic v, output logic e);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.x = a; bus.y = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    res = bus.result; v = bus.ovf; e = bus.err;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'b00; bus.x = '0; bus.y = '0;
    rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 16'h0)  begin n_bad++; $display("FAIL reset_result: got %h want 0000", bus.result); end
    n_cmp++; if (bus.ovf !== 1'b0)      begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_cmp++; if (bus.err !== 1'b0)      begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic test_add_sub();
    int lat; logic [15:0] res; logic v, e;
    for (int i = 0; i < 6; i++) begin
      run_op(as_op[i], as_x[i], as_y[i], lat, res, v, e);
      n_cmp++; if (lat != 2)          begin n_bad++; $display("FAIL addsub_lat[%0d]: got %0d want 2", i, lat); end
      n_cmp++; if (res !== as_res[i]) begin n_bad++; $display("FAIL addsub_res[%0d]: got %h want %h", i, res, as_res[i]); end
      n_cmp++; if (v !== as_ovf[i])   begin n_bad++; $display("FAIL addsub_ovf[%0d]: got %b want %b", i, v, as_ovf[i]); end
      n_cmp++; if (e !== 1'b0)        begin n_bad++; $display("FAIL addsub_err[%0d]: got %b want 0", i, e); end
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
  endtask

  task automatic test_mul_directed();
    int lat; logic [15:0] res; logic v, e;
    for (int i = 0; i < 7; i++) begin
      run_op(2'b10, m_x[i], m_y[i], lat, res, v, e);
      n_cmp++; if (res !== m_res[i]) begin n_bad++; $display("FAIL mul_res[%0d]: got %h want %h", i, res, m_res[i]); end
      n_cmp++; if (v !== 1'b0)       begin n_bad++; $display("FAIL mul_ovf[%0d]: got %b want 0", i, v); end
`ifndef ALU_CTRL_SKIP_EN
      n_cmp++; if (lat != 17)        begin n_bad++; $display("FAIL mul_lat[%0d]: got %0d want 17", i, lat); end
`else
      n_cmp++; if (lat < 9 || lat > 17) begin n_bad++; $display("FAIL mul_lat[%0d]: got %0d want 9..17", i, lat); end
`endif
    end
  endtask

  task automatic test_mul_random();
    int lat; logic [15:0] res; logic v, e;
    logic signed [7:0]  sa, sb;
    logic signed [15:0] expv;
    for (int i = 0; i < 100; i++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      expv = sa * sb;
      run_op(2'b10, sa, sb, lat, res, v, e);
      n_cmp++; if (res !== expv) begin n_bad++; $display("FAIL mul_rand[%0d]: %0d*%0d got %h want %h", i, sa, sb, res, expv); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat; bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.x = 8'd3; bus.y = 8'hFE;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 3) begin bus.start = 1'b1; bus.op = 2'b00; bus.x = 8'd1; bus.y = 8'd1; end
      if (k == 4) begin bus.start = 1'b0; bus.op = 2'b01; bus.x = 8'd99; bus.y = 8'd42; end
      if (bus.done) begin lat = k; break; end
    end
    n_cmp++; if (bus.result !== 16'hFFFA) begin n_bad++; $display("FAIL busy_ignore_res: got %h want fffa", bus.result); end
`ifndef ALU_CTRL_SKIP_EN
    n_cmp++; if (lat != 17) begin n_bad++; $display("FAIL busy_ignore_lat: got %0d want 17", lat); end
`else
    n_cmp++; if (lat != 10) begin n_bad++; $display("FAIL busy_ignore_lat: got %0d want 10", lat); end
`endif
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL busy_ignore_queued: got activity=%b want 0", seen); end
  endtask

  task automatic test_reserved();
    int lat; logic [15:0] res; logic v, e;
    run_op(2'b11, 8'd12, 8'd34, lat, res, v, e);
    n_cmp++; if (lat != 1)      begin n_bad++; $display("FAIL rsvd_lat: got %0d want 1", lat); end
    n_cmp++; if (e !== 1'b1)    begin n_bad++; $display("FAIL rsvd_err: got %b want 1", e); end
    n_cmp++; if (res !== 16'h0) begin n_bad++; $display("FAIL rsvd_res: got %h want 0000", res); end
    n_cmp++; if (v !== 1'b0)    begin n_bad++; $display("FAIL rsvd_ovf: got %b want 0", v); end
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.x = 8'd1; bus.y = 8'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++; if (bus.err !== 1'b0)  begin n_bad++; $display("FAIL err_clear: got %b want 0", bus.err); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b want 1", bus.busy); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = k; break; end
    end
    n_cmp++; if (bus.result !== 16'd2) begin n_bad++; $display("FAIL after_rsvd_res: got %h want 0002", bus.result); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [15:0] res; logic v, e;
    run_op(2'b00, 8'd3, 8'd2, lat, res, v, e);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_gap: got %b want 0", bus.busy); end
    run_op(2'b01, 8'd5, 8'd3, lat, res, v, e);
    n_cmp++; if (lat != 2)      begin n_bad++; $display("FAIL b2b_lat: got %0d want 2", lat); end
    n_cmp++; if (res !== 16'd2) begin n_bad++; $display("FAIL b2b_res: got %h want 0002", res); end
  endtask

  task automatic test_abort();
    int lat; logic [15:0] res; logic v, e; bit seen;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b10; bus.x = 8'd7; bus.y = 8'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_b = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0)    begin n_bad++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)    begin n_bad++; $display("FAIL abort_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 16'h0) begin n_bad++; $display("FAIL abort_result: got %h want 0000", bus.result); end
    n_cmp++; if ((bus.ovf | bus.err) !== 1'b0) begin n_bad++; $display("FAIL abort_flags: got %b%b want 00", bus.ovf, bus.err); end
    @(negedge clk);
    rst_b = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
    run_op(2'b10, 8'd5, 8'd5, lat, res, v, e);
    n_cmp++; if (res !== 16'd25) begin n_bad++; $display("FAIL abort_recover: got %h want 0019", res); end
  endtask

`ifdef ALU_CTRL_SKIP_EN
  task automatic test_skip();
    int lat; logic [15:0] res; logic v, e;
    run_op(2'b10, 8'd7, 8'd0, lat, res, v, e);
    n_cmp++; if (lat != 9)         begin n_bad++; $display("FAIL skip_lat_y0: got %0d want 9", lat); end
    n_cmp++; if (res !== 16'd0)    begin n_bad++; $display("FAIL skip_res_y0: got %h want 0000", res); end
    run_op(2'b10, 8'd7, 8'hFF, lat, res, v, e);
    n_cmp++; if (lat != 10)        begin n_bad++; $display("FAIL skip_lat_ym1: got %0d want 10", lat); end
    n_cmp++; if (res !== 16'hFFF9) begin n_bad++; $display("FAIL skip_res_ym1: got %h want fff9", res); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_mul_directed();
    test_busy_ignore();
    test_reserved();
    test_back_to_back();
    test_abort();
`ifdef ALU_CTRL_SKIP_EN
    test_skip();
`endif
    test_mul_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
